// File: rtl/mcdt_arbiter.sv
// Round-robin burst arbiter draining three show-ahead channel FIFOs into one
// registered valid/ready output carrying data plus source channel id.
module mcdt_arbiter #(
  parameter int DW    = 32,
  parameter int BURST = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] ch0_data_i,
  input  logic [DW-1:0] ch1_data_i,
  input  logic [DW-1:0] ch2_data_i,
  input  logic          ch0_val_i,
  input  logic          ch1_val_i,
  input  logic          ch2_val_i,
  input  logic          ch0_en_i,
  input  logic          ch1_en_i,
  input  logic          ch2_en_i,
  output logic          ch0_rd_o,
  output logic          ch1_rd_o,
  output logic          ch2_rd_o,
  input  logic          mcdt_rdy_i,
  output logic [DW-1:0] mcdt_data_o,
  output logic          mcdt_val_o,
  output logic [1:0]    mcdt_id_o,
  output logic          busy_o
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  localparam logic [3:0] LAST_CNT = 4'(BURST - 1);

  state_t        state_q, state_d;
  logic [1:0]    cur_q, cur_d;
  logic [1:0]    last_q, last_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          val_q, val_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    id_q, id_d;

  // Padded to four entries so a 2-bit channel index never selects out of range.
  logic [3:0]    elig;
  logic [DW-1:0] ch_data [4];
  logic [1:0]    cand1, cand2, pick;
  logic          pick_ok;
  logic          space, fire;

  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  assign elig       = {1'b0, ch2_val_i & ch2_en_i, ch1_val_i & ch1_en_i, ch0_val_i & ch0_en_i};
  assign ch_data[0] = ch0_data_i;
  assign ch_data[1] = ch1_data_i;
  assign ch_data[2] = ch2_data_i;
  assign ch_data[3] = '0;

  assign space = ~val_q | mcdt_rdy_i;
  assign fire  = (state_q == ST_GRANT) & elig[cur_q] & space;

  // Search order starts after the last-served channel and wraps back onto it.
  always_comb begin
    cand1   = next_ch(last_q);
    cand2   = next_ch(cand1);
    pick    = cand1;
    pick_ok = 1'b1;
    if (elig[cand1])       pick = cand1;
    else if (elig[cand2])  pick = cand2;
    else if (elig[last_q]) pick = last_q;
    else                   pick_ok = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    data_d  = data_q;
    id_d    = id_q;

    if (fire) begin
      data_d = ch_data[cur_q];
      id_d   = cur_q;
      val_d  = 1'b1;
      cnt_d  = cnt_q + 4'd1;
    end else if (val_q && mcdt_rdy_i) begin
      val_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_ok) begin
          cur_d   = pick;
          cnt_d   = 4'd0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A stalled-but-eligible channel keeps its grant; the stall is not charged.
        if ((fire && cnt_q == LAST_CNT) || !elig[cur_q]) begin
          state_d = ST_IDLE;
          last_d  = cur_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cur_q   <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= 4'd0;
      val_q   <= 1'b0;
      data_q  <= '0;
      id_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign ch0_rd_o    = fire & (cur_q == 2'd0);
  assign ch1_rd_o    = fire & (cur_q == 2'd1);
  assign ch2_rd_o    = fire & (cur_q == 2'd2);
  assign mcdt_data_o = data_q;
  assign mcdt_val_o  = val_q;
  assign mcdt_id_o   = id_q;
  assign busy_o      = (state_q == ST_GRANT);

endmodule

// File: tb/tb_mcdt_arbiter.sv
// Bench for mcdt_arbiter: per-cycle vector table, directed FIFO scenarios and a
// randomized run checked by a per-channel FIFO scoreboard.
module tb_mcdt_arbiter;
  localparam int DW    = 32;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] ch_data [3];
  logic [2:0]    ch_val, ch_en, ch_rd;
  logic          rdy;
  logic [DW-1:0] o_data;
  logic          o_val;
  logic [1:0]    o_id;
  logic          busy;

  always #5 clk = ~clk;

  mcdt_arbiter #(.DW(DW), .BURST(BURST)) dut (
    .clk_i(clk), .rst_i(rst),
    .ch0_data_i(ch_data[0]), .ch1_data_i(ch_data[1]), .ch2_data_i(ch_data[2]),
    .ch0_val_i(ch_val[0]), .ch1_val_i(ch_val[1]), .ch2_val_i(ch_val[2]),
    .ch0_en_i(ch_en[0]), .ch1_en_i(ch_en[1]), .ch2_en_i(ch_en[2]),
    .ch0_rd_o(ch_rd[0]), .ch1_rd_o(ch_rd[1]), .ch2_rd_o(ch_rd[2]),
    .mcdt_rdy_i(rdy), .mcdt_data_o(o_data), .mcdt_val_o(o_val),
    .mcdt_id_o(o_id), .busy_o(busy)
  );

  typedef struct packed {
    logic [2:0] val;
    logic [2:0] en;
    logic       rdy;
    logic [2:0] rd;
    logic       ov;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  // Channel FIFO model; eptr walks the same words to predict output order.
  logic [31:0] fmem [3][256];
  int          fhead [3];
  int          ftail [3];
  int          eptr  [3];
  logic [1:0]  got_id  [128];
  logic [31:0] got_dat [128];
  int          got_n;
  logic        ovlog [128];
  int          cyc_n;
  logic [1:0]  exp_id  [128];
  logic [31:0] exp_dat [128];
  int          exp_n;
  logic        prev_hold;
  logic [31:0] prev_dat;
  logic [1:0]  prev_id;
  int          run_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tot++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic logic [31:0] word(input int c, input int k);
    return 32'h00C0_0000 | (32'(c) << 16) | 32'(k);
  endfunction

  task automatic push_n(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[c][ftail[c]] = word(c, ftail[c]);
      ftail[c]++;
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      fhead[c] = 0; ftail[c] = 0; eptr[c] = 0;
    end
    got_n = 0; cyc_n = 0; exp_n = 0; prev_hold = 1'b0; run_len = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_val = 3'b000; ch_en = 3'b111; rdy = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock per iteration: drive from model, sample, score, then advance the edge.
  task automatic cyc(input int n);
    logic ok;
    for (int j = 0; j < n; j++) begin
      for (int c = 0; c < 3; c++) begin
        ch_val[c]  = (fhead[c] < ftail[c]);
        ch_data[c] = ch_val[c] ? fmem[c][fhead[c]] : (32'hBAD0_0000 | 32'(c));
      end
      #1;
      if (cyc_n < 128) ovlog[cyc_n] = o_val;
      cyc_n++;
      check("rd_onehot", 32'($countones(ch_rd) <= 1), 32'd1);
      ok = ((ch_rd & ~(ch_val & ch_en)) == 3'b000) && (ch_rd == 3'b000 || !o_val || rdy);
      check("rd_legal", 32'(ok), 32'd1);
      if (!busy) run_len = 0;
      if (ch_rd != 3'b000) begin
        run_len++;
        check("burst_len", 32'(run_len <= BURST), 32'd1);
      end
      if (prev_hold) begin
        check("hold_data", o_data, prev_dat);
        check("hold_id", 32'(o_id), 32'(prev_id));
      end
      prev_hold = o_val & ~rdy;
      prev_dat  = o_data;
      prev_id   = o_id;
      if (o_val && rdy) begin
        if (got_n < 128) begin
          got_id[got_n]  = o_id;
          got_dat[got_n] = o_data;
        end
        got_n++;
        if (o_id > 2'd2 || eptr[o_id] >= ftail[o_id]) begin
          n_tot++;
          $display("FAIL sb_unexpected: got id %0d data %h expected no word", o_id, o_data);
        end else begin
          check("sb_data", o_data, fmem[o_id][eptr[o_id]]);
          eptr[o_id]++;
        end
      end
      for (int c = 0; c < 3; c++)
        if (ch_rd[c] && fhead[c] < ftail[c]) fhead[c]++;
      @(posedge clk); #1;
    end
  endtask

  task automatic compare_seq(input string name);
    check({name, "_count"}, 32'(got_n), 32'(exp_n));
    for (int i = 0; i < exp_n && i < got_n && i < 128; i++) begin
      check({name, "_id"}, 32'(got_id[i]), 32'(exp_id[i]));
      check({name, "_data"}, got_dat[i], exp_dat[i]);
    end
  endtask

  task automatic add_exp(input int c, input int k);
    exp_id[exp_n]  = 2'(c);
    exp_dat[exp_n] = word(c, k);
    exp_n++;
  endtask

  task automatic exp_rr3();
    exp_n = 0;
    for (int i = 0; i < 24; i++) add_exp((i / 4) % 3, (i / 12) * 4 + i % 4);
  endtask

  vec_t        tbl [18];
  logic [14:0] t1_pat;
  int          rc;

  initial begin
    tbl[0]  = '{3'b000, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{3'b001, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{3'b001, 3'b111, 1'b1, 3'b001, 1'b0, 2'd0, 1'b1};
    tbl[3]  = '{3'b001, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1};
    tbl[4]  = '{3'b001, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1};
    tbl[5]  = '{3'b001, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1};
    tbl[6]  = '{3'b011, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1};
    tbl[7]  = '{3'b011, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1};
    tbl[8]  = '{3'b011, 3'b111, 1'b1, 3'b000, 1'b1, 2'd0, 1'b0};
    tbl[9]  = '{3'b011, 3'b111, 1'b1, 3'b010, 1'b0, 2'd0, 1'b1};
    tbl[10] = '{3'b011, 3'b101, 1'b1, 3'b000, 1'b1, 2'd1, 1'b1};
    tbl[11] = '{3'b011, 3'b101, 1'b1, 3'b000, 1'b0, 2'd1, 1'b0};
    tbl[12] = '{3'b011, 3'b101, 1'b0, 3'b001, 1'b0, 2'd1, 1'b1};
    tbl[13] = '{3'b000, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1};
    tbl[14] = '{3'b100, 3'b111, 1'b1, 3'b000, 1'b1, 2'd0, 1'b0};
    tbl[15] = '{3'b100, 3'b111, 1'b1, 3'b100, 1'b0, 2'd0, 1'b1};
    tbl[16] = '{3'b000, 3'b111, 1'b1, 3'b000, 1'b1, 2'd2, 1'b1};
    tbl[17] = '{3'b000, 3'b111, 1'b1, 3'b000, 1'b0, 2'd2, 1'b0};

    for (int c = 0; c < 3; c++) ch_data[c] = 32'h0;
    ch_val = 3'b000; ch_en = 3'b111; rdy = 1'b1;
    model_reset();

    // Reset values while reset is held
    @(posedge clk); #1;
    check("rst_val", 32'(o_val), 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_id", 32'(o_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd", 32'(ch_rd), 32'd0);

    // Per-cycle vector table
    do_reset();
    for (int r = 0; r < 18; r++) begin
      ch_val = tbl[r].val; ch_en = tbl[r].en; rdy = tbl[r].rdy;
      for (int c = 0; c < 3; c++) ch_data[c] = 32'h00D0_0000 | 32'(c);
      #1;
      check($sformatf("tbl%0d_rd", r), 32'(ch_rd), 32'(tbl[r].rd));
      check($sformatf("tbl%0d_val", r), 32'(o_val), 32'(tbl[r].ov));
      check($sformatf("tbl%0d_id", r), 32'(o_id), 32'(tbl[r].id));
      check($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
      if (tbl[r].ov) check($sformatf("tbl%0d_data", r), o_data, 32'h00D0_0000 | 32'(tbl[r].id));
      @(posedge clk); #1;
    end

    // Single channel, 10 words: order, ids and 4-on/1-off valid pattern
    do_reset();
    push_n(0, 10);
    cyc(16);
    exp_n = 0;
    for (int i = 0; i < 10; i++) add_exp(0, i);
    compare_seq("t1");
    t1_pat = 15'b011011110111100;
    for (int i = 0; i < 15; i++) check($sformatf("t1_valid%0d", i), 32'(ovlog[i]), 32'(t1_pat[i]));

    // Three full channels, rotating bursts
    do_reset();
    for (int c = 0; c < 3; c++) push_n(c, 8);
    cyc(40);
    exp_rr3();
    compare_seq("t2");

    // Same with a 5-cycle downstream stall mid-burst
    do_reset();
    for (int c = 0; c < 3; c++) push_n(c, 8);
    cyc(3);
    rdy = 1'b0;
    check("t3_stall_valid", 32'(o_val), 32'd1);
    cyc(5);
    rdy = 1'b1;
    cyc(40);
    exp_rr3();
    compare_seq("t3");

    // ch1 disabled, then re-admitted
    do_reset();
    ch_en = 3'b101;
    for (int c = 0; c < 3; c++) push_n(c, 8);
    cyc(30);
    check("t4_ch1_untouched", 32'(fhead[1]), 32'd0);
    ch_en = 3'b111;
    cyc(16);
    exp_n = 0;
    for (int i = 0; i < 16; i++) add_exp(((i / 4) % 2) * 2, (i / 8) * 4 + i % 4);
    for (int i = 0; i < 8; i++) add_exp(1, i);
    compare_seq("t4");

    // Dry channel ends its grant early and becomes last-served
    do_reset();
    push_n(0, 4); cyc(8);
    push_n(2, 2); cyc(6);
    push_n(0, 1); push_n(1, 1); cyc(10);
    exp_n = 0;
    for (int i = 0; i < 4; i++) add_exp(0, i);
    add_exp(2, 0); add_exp(2, 1); add_exp(0, 4); add_exp(1, 0);
    compare_seq("t5");

    // Asynchronous reset mid-burst
    do_reset();
    push_n(0, 8);
    cyc(3);
    check("t6_pre_val", 32'(o_val), 32'd1);
    check("t6_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_val", 32'(o_val), 32'd0);
    check("t6_data", o_data, 32'd0);
    check("t6_id", 32'(o_id), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_rd", 32'(ch_rd), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    push_n(0, 8); push_n(1, 4);
    cyc(20);
    exp_n = 0;
    for (int i = 0; i < 4; i++) add_exp(0, i);
    for (int i = 0; i < 4; i++) add_exp(1, i);
    for (int i = 4; i < 8; i++) add_exp(0, i);
    compare_seq("t6");

    // Randomized traffic, enables and backpressure
    do_reset();
    for (int j = 0; j < 800; j++) begin
      if ($urandom_range(0, 2) == 0) begin
        rc = int'($urandom_range(0, 2));
        if (ftail[rc] < 250) push_n(rc, 1);
      end
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) ch_en = 3'($urandom_range(0, 7));
      cyc(1);
    end
    ch_en = 3'b111; rdy = 1'b1;
    cyc(600);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("rand_drain_out%0d", c), 32'(eptr[c]), 32'(ftail[c]));
      check($sformatf("rand_drain_pop%0d", c), 32'(fhead[c]), 32'(ftail[c]));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mcdt_arbiter.md
# mcdt_arbiter

Round-robin burst arbiter that drains three per-channel show-ahead FIFOs into the single MCDT output port. It sits between the channel slave FIFOs and the formatter stage. It grants one channel at a time for up to BURST words, then rotates to the next eligible channel. The output is a registered valid/ready stage carrying data plus the source channel id.

## Interface
- DW, 32, data width of channel and output words
- BURST, 4, maximum words per grant; legal range 1..15

- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- ch0_data_i / ch1_data_i / ch2_data_i  in  DW  head word of channel FIFO (show-ahead)
- ch0_val_i / ch1_val_i / ch2_val_i  in  1  channel FIFO non-empty
- ch0_en_i / ch1_en_i / ch2_en_i  in  1  channel enable; a disabled channel is never granted or popped
- ch0_rd_o / ch1_rd_o / ch2_rd_o  out  1  pop strobe to channel FIFO, combinational, one-hot or zero
- mcdt_rdy_i  in  1  downstream ready
- mcdt_data_o  out  DW  output word, registered
- mcdt_val_o  out  1  output word valid, registered
- mcdt_id_o  out  2  source channel of mcdt_data_o (0..2), registered
- busy_o  out  1  high when FSM is in GRANT

## Operation
- Internal state: FSM {IDLE, GRANT}; cur[1:0] granted channel; last[1:0] last-served channel; cnt[3:0] words sent in current grant.
- elig[n] = chn_val_i & chn_en_i.
- IDLE: if any elig, select the first eligible channel in order (last+1), (last+2), (last+3) mod 3. Then load cur, clear cnt, go to GRANT. No pop occurs in an IDLE cycle.
- space = ~mcdt_val_o | mcdt_rdy_i.
- fire = (state==GRANT) & elig[cur] & space.
- ch{cur}_rd_o = fire. All other rd_o are 0.
- On fire: mcdt_data_o <= ch{cur}_data_i, mcdt_id_o <= cur, mcdt_val_o <= 1, cnt <= cnt+1.
- No fire and mcdt_val_o & mcdt_rdy_i: mcdt_val_o <= 0.
- mcdt_data_o and mcdt_id_o hold their values while mcdt_val_o is low.
- GRANT exits to IDLE, with last <= cur, when either:
  - (a) fire with cnt==BURST-1 (burst complete), or
  - (b) ~elig[cur] with no fire (channel ran dry or was disabled).
- A stall from ~space with elig[cur] high stays in GRANT. The downstream stall does not count against the burst.
- Channel word order is preserved. A word is popped exactly once and appears on the output exactly once.

## Timing
- Reset values:
  - state=IDLE, last=2 (so channel 0 is served first), cur=0, cnt=0
  - mcdt_val_o=0, mcdt_data_o=0, mcdt_id_o=0, busy_o=0
  - all rd_o=0
- Reset mid-burst aborts immediately. A held output word is dropped. Words already popped are lost, by design.
- Latency: elig sampled at edge k in IDLE → GRANT after edge k. The pop occurs in the cycle after edge k. mcdt_val_o is high after edge k+1, giving 2 cycles from an idle request to valid output.
- Throughput, with rdy=1 and all channels full: BURST words per BURST+1 cycles. There is a 1-cycle IDLE bubble between grants.
- Output handshake: a word transfers on a rising edge where mcdt_val_o & mcdt_rdy_i. While mcdt_val_o & ~mcdt_rdy_i, data and id are held stable.
- Simultaneous transfer-out and fire in the same cycle: the new word replaces the old one with no bubble. mcdt_val_o stays 1.
- chn_en_i dropping during a grant: no pop in that cycle, and the FSM returns to IDLE at the next edge.
- BURST=1: every grant carries exactly one word, followed by one IDLE cycle.
- A single eligible channel is re-granted after each burst, separated by the IDLE cycle.

## Test plan
- Reset, then ch0 loaded with 0x00C0_0000..0x00C0_0009, BURST=4, rdy=1 → output has 10 words in order, all id=0. Valid pattern is 4 on / 1 off, 4 on / 1 off, 2 on. First valid appears 2 cycles after ch0_val_i rises.
- All three channels each loaded with 8 words (0x00Cn_000k), rdy=1 → ids sequence 0,0,0,0,1,1,1,1,2,2,2,2,0,0,0,0,1,1,1,1,2,2,2,2. No word lost or duplicated.
- As the previous test, with mcdt_rdy_i low for 5 cycles mid-burst → data and id are held stable. No rd_o pulses occur during the stall. The burst resumes and still totals 4 words for that grant.
- ch1_en_i=0 with all channels full → ch1 is never popped and ch1_rd_o stays 0. Ids alternate in blocks 0×4, 2×4. Raising ch1_en_i then re-admits ch1 in round-robin order.
- ch2 holds 2 words with BURST=4 → grant ends after 2 words because the channel ran dry. last=2, so ch0 is the next channel granted.
- rst_i asserted mid-burst on ch0 → all outputs are 0 immediately, asynchronously. After release, channel 0 is served first with cnt restarting at 0.
